spi_flash_loader: RTL and testbench
===================================

# spi_flash_loader

SPI slave-side program loader inside `mpw_top`. It receives the byte stream from the external SPI master while the core is held in reset and turns it into 32-bit memory write transactions. Targets are instruction memory, data memory and the PIM SRAM window. Command `0x01` loads a 4-byte address and command `0x02` loads a 4-byte data word; both are sent MSB first, and each completed data word issues one write.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `sclk`/`cs_n`/`mosi` before edge detection (≥2).
- `CMD_ADDR`, 8'h01: opcode; next 4 bytes form the write address, MSB first.
- `CMD_DATA`, 8'h02: opcode; next 4 bytes form the write data, MSB first.
- `CMD_ABORT`, 8'hFF: opcode; returns the FSM to `CMD` and clears `o_overrun`.
- `clk  in  1`  system clock; the only clock.
- `reset  in  1`  synchronous, active-high reset.
- `sclk  in  1`  SPI clock, asynchronous to `clk`, mode 0.
- `cs_n  in  1`  SPI chip select, active low.
- `mosi  in  1`  SPI data in.
- `miso  out  1`  SPI data out: echo of the previous received byte.
- `o_wr_en  out  1`  write request; held until accepted.
- `o_wr_addr  out  32`  write address.
- `o_wr_data  out  32`  write data.
- `i_wr_ready  in  1`  write accepted on any cycle where `o_wr_en && i_wr_ready`.
- `o_overrun  out  1`  sticky flag: a byte was dropped while a write was pending.
- `o_busy  out  1`  high whenever FSM ≠ `CMD`.

## Operation
- **Synchronization:** inputs pass through `SYNC_STAGES` flops. `rise`/`fall` are one-cycle strobes from the last two `sclk` samples, qualified by synchronized `cs_n` low.
- **Receive path:** on `rise`, shift `mosi` into an 8-bit register, MSB first, and increment a 3-bit bit counter. When the counter wraps 7→0, a one-cycle `byte_done` strobe fires.
- **Transmit path:** on `fall`, shift the tx register left; `miso` = tx[7]. At `byte_done` the tx register loads the byte just received.
- **Deselect:** synchronized `cs_n` high clears the bit counter and discards any partial byte. It does NOT reset the FSM, because the master deasserts `cs_n` between bytes.
- **FSM states:** `CMD`, `ADDR`, `DATA`, `WRITE`. A 2-bit byte counter tracks bytes within `ADDR`/`DATA`.
  - `CMD` + `byte_done`:
    - `CMD_ADDR` → `ADDR`
    - `CMD_DATA` → `DATA`
    - `CMD_ABORT` → `CMD`
    - any other byte is ignored and the FSM stays in `CMD`.
  - `ADDR`: each byte shifts into `o_wr_addr` (`{addr[23:0],byte}`). After the 4th byte → `CMD`.
  - `DATA`: each byte shifts into the data holding register. After the 4th byte → `WRITE` and `o_wr_en` is set.
  - `WRITE`: hold `o_wr_en`, `o_wr_addr`, `o_wr_data` stable until `i_wr_ready`. Then clear `o_wr_en`, apply the configuration rule to `o_wr_addr`, and go to `CMD`.
  - `byte_done` while in `WRITE`: the byte is dropped and `o_overrun` is set. `CMD_ABORT` received in `CMD` clears `o_overrun`.
- **Acceptance:** a write accepted in the same cycle as `byte_done` is legal. The write completes and the byte is decoded in `CMD`, and is not counted as an overrun.
- **Address arithmetic:** modulo 2^32; `32'hFFFF_FFFC` + 4 → `32'h0000_0000`.

## Timing
- **Reset values:** `miso`=0, `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_overrun`=0, `o_busy`=0; FSM=`CMD`; bit/byte counters=0; tx register=0; sync flops=`sclk` 0, `cs_n` 1, `mosi` 0.
- **Reset mid-transfer:** the partial byte and any pending write are abandoned with no write issued.
- **SCLK rate:** `sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk` periods. At `SYNC_STAGES`=2 this means f_sclk ≤ f_clk/8.
- **Byte latency:** `byte_done` is asserted `SYNC_STAGES`+1 cycles after the raw 8th `sclk` rising edge.
- **Write latency:** `o_wr_en` rises 1 cycle after the `byte_done` of the 4th data byte.
- **Write acceptance:** `o_wr_en` falls the cycle after acceptance. Minimum pulse is 1 cycle when `i_wr_ready` is already high.
- **`miso` validity:** `miso` changes ≤ `SYNC_STAGES`+1 cycles after a raw falling edge, so it is valid before the next rising edge.

## Configuration
- Macro: `SPI_FLASH_LOADER_AUTOINC_EN`.
- **Defined:** on write acceptance, `o_wr_addr` += 4. Consecutive `0x02`+4-byte frames therefore write sequential words without resending the address.
- **Undefined:** `o_wr_addr` is unchanged after a write; each word needs its own `0x01` frame or it overwrites the same address.

## Test plan
- **Single write:** reset; send `01 10 00 00 00`, then `02 DE AD BE EF`, with `i_wr_ready`=1. → exactly one write at addr `32'h1000_0000`, data `32'hDEAD_BEEF`; `o_busy` low afterwards.
- **Auto-increment (macro defined):** after the single write, send `02 00 00 00 13` twice. → writes at `32'h1000_0004` then `32'h1000_0008`. Macro undefined: both writes go to `32'h1000_0000`.
- **Backpressure:** hold `i_wr_ready`=0 for 50 cycles after `o_wr_en` rises. → `o_wr_en`/addr/data stay stable; one write when ready goes high.
  - Sending byte `AA` during the stall sets `o_overrun` and produces no write.
  - Then send `FF`. → `o_overrun` clears.
- **Partial byte and unknown opcode:** drop `cs_n` after 5 bits, then send `01 20 00 00 30`. → partial byte discarded; addr = `32'h2000_0030`. Unknown opcode `7E` in `CMD` → ignored, FSM stays `CMD`.
- **Echo and mid-transfer reset:**
  - Send `01` then `5A`. → `miso` shifts out `8'h01` during the `5A` byte.
  - Assert `reset` after `02 11 22`. → no write, all outputs at reset values; a following full `02` frame writes correctly.

Source files
------------

// File: rtl/spi_flash_loader.sv
// rtl/spi_flash_loader.sv - SPI slave byte receiver that turns command frames into 32-bit memory writes.
// Optional feature: define SPI_FLASH_LOADER_AUTOINC_EN to advance o_wr_addr by 4 after each accepted write.
module spi_flash_loader #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_ADDR    = 8'h01,
    parameter logic [7:0]  CMD_DATA    = 8'h02,
    parameter logic [7:0]  CMD_ABORT   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    input  logic        i_wr_ready,
    output logic        o_overrun,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_byte_done;
    logic [7:0]  r_tx;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_hold;
    logic [31:0] r_wr_data;
    logic        r_wr_en;
    logic        r_overrun;

    logic        w_sclk_s;
    logic        w_cs_s;
    logic        w_mosi_s;
    logic        w_rise;
    logic        w_fall;
    logic        w_accept;
    logic        w_is_abort;
    state_t      w_cmd_next;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   =  w_sclk_s & ~r_sclk_d & ~w_cs_s;
    assign w_fall   = ~w_sclk_s &  r_sclk_d & ~w_cs_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
        end
    end

    // The trailing fall after bit 8 (counter already wrapped) must not shift,
    // otherwise the freshly loaded echo byte would lose its MSB before bit 1 is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_byte      <= 8'd0;
            r_byte_done <= 1'b0;
            r_tx        <= 8'd0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_cs_s) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[6:0], w_mosi_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_done <= 1'b1;
                    r_byte      <= {r_shift[6:0], w_mosi_s};
                end
            end
            if (r_byte_done) begin
                r_tx <= r_byte;
            end else if (w_fall && (r_bit_cnt != 3'd0)) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_cmd_next = ST_CMD;
        w_is_abort = 1'b0;
        if (r_byte == CMD_ADDR) begin
            w_cmd_next = ST_ADDR;
        end else if (r_byte == CMD_DATA) begin
            w_cmd_next = ST_DATA;
        end else if (r_byte == CMD_ABORT) begin
            w_is_abort = 1'b1;
        end
    end

    assign w_accept = r_wr_en & i_wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CMD;
            r_byte_cnt <= 2'd0;
            r_addr     <= 32'd0;
            r_hold     <= 32'd0;
            r_wr_data  <= 32'd0;
            r_wr_en    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (r_byte_done) begin
                        r_state    <= w_cmd_next;
                        r_byte_cnt <= 2'd0;
                        if (w_is_abort) begin
                            r_overrun <= 1'b0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (r_byte_done) begin
                        r_addr     <= {r_addr[23:0], r_byte};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= ST_CMD;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_byte_done) begin
                        r_hold     <= {r_hold[23:0], r_byte};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wr_data <= {r_hold[23:0], r_byte};
                            r_wr_en   <= 1'b1;
                            r_state   <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        r_wr_en <= 1'b0;
`ifdef SPI_FLASH_LOADER_AUTOINC_EN
                        r_addr  <= r_addr + 32'd4;
`endif
                        r_state <= ST_CMD;
                        // A byte finishing in the acceptance cycle is decoded as a command, not dropped.
                        if (r_byte_done) begin
                            r_state    <= w_cmd_next;
                            r_byte_cnt <= 2'd0;
                            if (w_is_abort) begin
                                r_overrun <= 1'b0;
                            end
                        end
                    end else if (r_byte_done) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= ST_CMD;
            endcase
        end
    end

    assign miso      = r_tx[7];
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_addr;
    assign o_wr_data = r_wr_data;
    assign o_overrun = r_overrun;
    assign o_busy    = (r_state != ST_CMD);

endmodule

// File: tb/tb_spi_flash_loader.sv
// tb/tb_spi_flash_loader.sv - directed SPI frames checked against a frame-level loader model.
module tb_spi_flash_loader;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        i_wr_ready = 1'b1;
    logic        miso;
    logic        o_wr_en;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_overrun;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    // Model state (written by the stimulus process only)
    int          m_mode = 0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_hold = 32'd0;
    logic        m_ovr = 1'b0;
    logic [31:0] exp_addr [0:63];
    logic [31:0] exp_data [0:63];
    int          n_exp = 0;

    // Written by the compare process only
    int          n_acc = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;

    logic [7:0]  cap;

    spi_flash_loader dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_wr_ready (i_wr_ready),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (n_exp != n_acc) begin
            m_ovr = 1'b1;
        end else if (m_mode == 0) begin
            m_cnt = 0;
            if (b == 8'h01) m_mode = 1;
            else if (b == 8'h02) m_mode = 2;
            else if (b == 8'hFF) m_ovr = 1'b0;
        end else if (m_mode == 1) begin
            m_addr = (m_addr << 8) | {24'd0, b};
            m_cnt++;
            if (m_cnt == 4) m_mode = 0;
        end else begin
            m_hold = (m_hold << 8) | {24'd0, b};
            m_cnt++;
            if (m_cnt == 4) begin
                exp_addr[n_exp] = m_addr;
                exp_data[n_exp] = m_hold;
                n_exp++;
                m_mode = 0;
`ifdef SPI_FLASH_LOADER_AUTOINC_EN
                m_addr = m_addr + 32'd4;
`endif
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        cs_n = 1'b0;
        repeat (HALF) cyc();
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            repeat (HALF) cyc();
            cap[7-i] = miso;
            sclk = 1'b1;
            repeat (HALF) cyc();
            sclk = 1'b0;
        end
        repeat (HALF) cyc();
        cs_n = 1'b1;
        repeat (8) cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_bits(b, 8);
        check("busy", {31'd0, o_busy}, {31'd0, (m_mode != 0) || (n_exp != n_acc)});
        check("overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
    endtask

    task automatic check_reset_outputs();
        check("rst miso", {31'd0, miso}, 32'd0);
        check("rst wr_en", {31'd0, o_wr_en}, 32'd0);
        check("rst wr_addr", o_wr_addr, 32'd0);
        check("rst wr_data", o_wr_data, 32'd0);
        check("rst overrun", {31'd0, o_overrun}, 32'd0);
        check("rst busy", {31'd0, o_busy}, 32'd0);
    endtask

    // Compare process: every accepted write against the model, and stability while stalled.
    initial begin : compare
        logic        p_en;
        logic        p_acc;
        logic [31:0] p_addr;
        logic [31:0] p_data;
        p_en = 1'b0;
        p_acc = 1'b0;
        p_addr = '0;
        p_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_en = 1'b0;
                p_acc = 1'b0;
            end else begin
                if (p_en && !p_acc) begin
                    check("wr_en held", {31'd0, o_wr_en}, 32'd1);
                    check("addr stable", o_wr_addr, p_addr);
                    check("data stable", o_wr_data, p_data);
                end
                if (o_wr_en && i_wr_ready) begin
                    if (n_acc >= n_exp) begin
                        check("unexpected write", 32'd1, 32'd0);
                    end else begin
                        check("write addr", o_wr_addr, exp_addr[n_acc]);
                        check("write data", o_wr_data, exp_data[n_acc]);
                    end
                    last_addr = o_wr_addr;
                    last_data = o_wr_data;
                    n_acc++;
                end
                p_en = o_wr_en;
                p_acc = o_wr_en && i_wr_ready;
                p_addr = o_wr_addr;
                p_data = o_wr_data;
            end
        end
    end

    initial begin : stim
        logic [7:0] frame [0:4];
        for (int i = 0; i < 64; i++) begin
            exp_addr[i] = '0;
            exp_data[i] = '0;
        end
        repeat (5) cyc();
        reset = 1'b0;
        cyc();
        check_reset_outputs();

        // Single write
        frame = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        frame = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        check("t1 count", n_acc, 32'd1);
        check("t1 addr", last_addr, 32'h1000_0000);
        check("t1 data", last_data, 32'hDEAD_BEEF);
        check("t1 busy", {31'd0, o_busy}, 32'd0);

        // Two data-only frames
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13};
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 5; i++) send_byte(frame[i]);
        check("t2 count", n_acc, 32'd3);
`ifdef SPI_FLASH_LOADER_AUTOINC_EN
        check("t2 addr", last_addr, 32'h1000_0008);
`else
        check("t2 addr", last_addr, 32'h1000_0000);
`endif
        check("t2 data", last_data, 32'h0000_0013);

        // Backpressure, overrun and abort
        i_wr_ready = 1'b0;
        frame = '{8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        for (int i = 0; i < 4; i++) send_byte(frame[i]);
        model_byte(frame[4]);
        send_bits(frame[4], 8);
        for (int k = 0; k < 100 && !o_wr_en; k++) cyc();
        check("t3 wr_en rise", {31'd0, o_wr_en}, 32'd1);
        repeat (50) cyc();
        send_byte(8'hAA);
        check("t3 overrun set", {31'd0, o_overrun}, 32'd1);
        check("t3 no write yet", n_acc, 32'd3);
        i_wr_ready = 1'b1;
        repeat (3) cyc();
        check("t3 count", n_acc, 32'd4);
        check("t3 data", last_data, 32'hCAFE_BABE);
        check("t3 wr_en low", {31'd0, o_wr_en}, 32'd0);
        send_byte(8'hFF);
        check("t3 overrun clr", {31'd0, o_overrun}, 32'd0);

        // Partial byte then address frame; unknown opcode
        send_bits(8'hB5, 5);
        frame = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h30};
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        check("t4 addr", o_wr_addr, 32'h2000_0030);
        send_byte(8'h7E);
        check("t4 busy", {31'd0, o_busy}, 32'd0);
        frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h55};
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        check("t4 write addr", last_addr, 32'h2000_0030);

        // Echo of previous byte on miso
        send_byte(8'h01);
        send_byte(8'h5A);
        check("t5 echo", {24'd0, cap}, 32'h0000_0001);
        send_byte(8'h00);
        check("t5 echo2", {24'd0, cap}, 32'h0000_005A);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t5 addr", o_wr_addr, 32'h5A00_0000);

        // Reset mid-frame
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        m_mode = 0;
        m_cnt = 0;
        m_addr = 32'd0;
        m_hold = 32'd0;
        m_ovr = 1'b0;
        cyc();
        check_reset_outputs();
        check("t5 no write", n_acc, 32'd5);
        frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        check("t5 post addr", last_addr, 32'h0000_0000);
        check("t5 post data", last_data, 32'h1234_5678);

        repeat (10) cyc();
        check("write count", n_acc, n_exp);
        check("total writes", n_acc, 32'd6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
